// File: rtl/xs3_serial_decoder.sv
// Bit-serial Excess-3 receiver: collects LSB-first nibbles, converts each code to BCD
// and presents the packed frame on a valid/ready interface with input backpressure.
module xs3_serial_decoder #(
    parameter int NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_bit,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic                   in_ready,
    output logic [4*NDIGITS-1:0]   out_data,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_abort
);

    localparam int DW  = 4 * NDIGITS;
    localparam int DCW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [DCW-1:0] LAST_DIG = DCW'(NDIGITS - 1);
    localparam logic [DCW-1:0] DIG_ONE  = DCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Excess-3 back to BCD; 4-bit wrap keeps invalid codes well defined.
    function automatic logic [3:0] xs3_to_bcd(input logic [3:0] code);
        return code - 4'd3;
    endfunction

    function automatic logic xs3_invalid(input logic [3:0] code);
        return (code < 4'd3) || (code > 4'd12);
    endfunction

    state_t             state_q,     state_d;
    logic [1:0]         bitcnt_q,    bitcnt_d;
    logic [DCW-1:0]     digcnt_q,    digcnt_d;
    logic [2:0]         nib_q,       nib_d;
    logic [DW-1:0]      data_q,      data_d;
    logic               err_acc_q,   err_acc_d;
    logic               out_err_q,   out_err_d;
    logic               out_valid_q, out_valid_d;
    logic               abort_q,     abort_d;
    logic               in_ready_q,  in_ready_d;

    logic               accept_s;
    logic [3:0]         code_s;
    logic               code_bad_s;

    assign accept_s   = in_valid && in_ready_q;
    assign code_s     = {in_bit, nib_q};
    assign code_bad_s = xs3_invalid(code_s);

    // Next-state and datapath update for the receive FSM.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        digcnt_d    = digcnt_q;
        nib_d       = nib_q;
        data_d      = data_q;
        err_acc_d   = err_acc_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        abort_d     = 1'b0;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_sof) begin
                    nib_d     = {2'b00, in_bit};
                    bitcnt_d  = 2'd1;
                    digcnt_d  = '0;
                    err_acc_d = 1'b0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (accept_s && in_sof) begin
                    // Resync: this bit starts a fresh frame, partial digits are dropped.
                    abort_d   = 1'b1;
                    nib_d     = {2'b00, in_bit};
                    bitcnt_d  = 2'd1;
                    digcnt_d  = '0;
                    err_acc_d = 1'b0;
                    data_d    = '0;
                end else if (accept_s && (bitcnt_q == 2'd3)) begin
                    data_d[{digcnt_q, 2'b00} +: 4] = xs3_to_bcd(code_s);
                    err_acc_d = err_acc_q | code_bad_s;
                    bitcnt_d  = 2'd0;
                    nib_d     = 3'd0;
                    if (digcnt_q == LAST_DIG) begin
                        digcnt_d    = '0;
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_err_d   = err_acc_q | code_bad_s;
                        in_ready_d  = 1'b0;
                    end else begin
                        digcnt_d    = digcnt_q + DIG_ONE;
                    end
                end else if (accept_s) begin
                    nib_d[bitcnt_q] = in_bit;
                    bitcnt_d        = bitcnt_q + 2'd1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d     = ST_HOLD;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                bitcnt_d    = 2'd0;
                digcnt_d    = '0;
                nib_d       = 3'd0;
                err_acc_d   = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 2'd0;
            digcnt_q    <= '0;
            nib_q       <= 3'd0;
            data_q      <= '0;
            err_acc_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            digcnt_q    <= digcnt_d;
            nib_q       <= nib_d;
            data_q      <= data_d;
            err_acc_q   <= err_acc_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            abort_q     <= abort_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = data_q;
    assign out_err     = out_err_q;
    assign out_valid   = out_valid_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_xs3_serial_decoder.sv
// Directed bench for xs3_serial_decoder with a frame-level reference model checked every cycle.
module tb_xs3_serial_decoder;

    localparam int N  = 2;
    localparam int DW = 4 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic          out_valid;
    logic          frame_abort;

    int total = 0;
    int bad = 0;
    int abort_seen = 0;

    xs3_serial_decoder #(.NDIGITS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of accepted bits since the last sof.
    bit            m_bits[$];
    bit            m_hold;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    logic          exp_abort;

    task automatic model_finish_frame();
        int code;
        exp_data = '0;
        exp_err  = 1'b0;
        for (int d = 0; d < N; d++) begin
            code = 0;
            for (int b = 0; b < 4; b++) code += int'(m_bits[4*d+b]) << b;
            exp_data[4*d +: 4] = 4'(code - 3);
            if (code < 3 || code > 12) exp_err = 1'b1;
        end
        m_bits.delete();
        m_hold = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bits.delete();
            m_hold    = 1'b0;
            exp_abort = 1'b0;
        end else begin
            exp_abort = 1'b0;
            if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                if (in_sof) begin
                    if (m_bits.size() > 0) exp_abort = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(in_bit);
                end else if (m_bits.size() > 0) begin
                    m_bits.push_back(in_bit);
                end
                if (m_bits.size() == 4 * N) model_finish_frame();
            end
        end
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_hold));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("frame_abort", 32'(frame_abort), 32'(exp_abort));
        if (frame_abort === 1'b1) abort_seen++;
        if (m_hold) begin
            chk("out_data", 32'(out_data), 32'(exp_data));
            chk("out_err", 32'(out_err), 32'(exp_err));
        end
    end

    task automatic drive(input logic b, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = s;
    endtask

    task automatic send_code(input logic [3:0] c, input logic first);
        for (int i = 0; i < 4; i++) drive(c[i], first && (i == 0));
    endtask

    task automatic send_frame(input logic [3:0] c0, input logic [3:0] c1);
        send_code(c0, 1'b1);
        send_code(c1, 1'b0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            if (out_valid === 1'b1) break;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int a0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h0);

        // Basic frame 0x8, 0x4 with consumer always ready.
        out_ready = 1'b1;
        send_frame(4'h8, 4'h4);
        wait_valid();
        chk("t1_data", 32'(out_data), 32'h15);
        chk("t1_err", 32'(out_err), 32'd0);
        @(negedge clk);
        chk("t1_drop", 32'(out_valid), 32'd0);
        chk("t1_keep", 32'(out_data), 32'h15);
        chk("t1_idle_ready", 32'(in_ready), 32'd1);

        // Invalid code.
        send_frame(4'hF, 4'h3);
        wait_valid();
        chk("t2_data", 32'(out_data), 32'h0C);
        chk("t2_err", 32'(out_err), 32'd1);

        // Backpressure: sof bits offered while holding are not taken.
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(4'h7, 4'h9);
        wait_valid();
        chk("t3_data", 32'(out_data), 32'h64);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1);
            chk("t3_hold_ready", 32'(in_ready), 32'd0);
            chk("t3_hold_data", 32'(out_data), 32'h64);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_valid", 32'(out_valid), 32'd0);
        chk("t3_release_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        send_code(4'h3, 1'b0);
        wait_valid();
        chk("t3_next_data", 32'(out_data), 32'h05);
        chk("t3_next_err", 32'(out_err), 32'd0);

        // Abort after 6 bits, resync on frame 0xC, 0x3.
        a0 = abort_seen;
        send_code(4'h5, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        send_frame(4'hC, 4'h3);
        wait_valid();
        chk("t4_data", 32'(out_data), 32'h09);
        chk("t4_err", 32'(out_err), 32'd0);
        chk("t4_abort_cnt", 32'(abort_seen - a0), 32'd1);

        // Idle garbage then a valid frame.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0);
        send_frame(4'h9, 4'hB);
        wait_valid();
        chk("t5_data", 32'(out_data), 32'h86);
        chk("t5_err", 32'(out_err), 32'd0);

        // Asynchronous reset mid-frame (partial frame holds an invalid code).
        @(negedge clk);
        send_code(4'h0, 1'b1);
        drive(1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'h0);
        chk("t6_rst_err", 32'(out_err), 32'd0);
        chk("t6_rst_abort", 32'(frame_abort), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(4'h4, 4'h5);
        wait_valid();
        chk("t6_data", 32'(out_data), 32'h21);
        chk("t6_err", 32'(out_err), 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
